dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache that sits between the CPU's MEM stage (EX_MEM address/write-data/MemRead/MemWrite) and a slow main memory with 256-bit block transfers. Hits complete in the requesting cycle with no stall. Misses assert a stall that freezes the whole pipeline while the controller writes back a dirty victim and refills the line over a request/acknowledge handshake.

## Interface
- `NUM_LINES`, default 32: lines in the cache (index width = log2).
- `BLOCK_BITS`, default 256: line size (32 bytes, 8 words).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-low.
- `p1_req_i`  in  1  MEM stage request valid (`MemRead | MemWrite`).
- `p1_MemRead_i`  in  1  load.
- `p1_MemWrite_i`  in  1  store; wins if both read and write are high.
- `p1_addr_i`  in  32  byte address; `[1:0]` ignored.
- `p1_data_i`  in  32  store data.
- `p1_data_o`  out  32  load data; valid when `p1_req_i & p1_MemRead_i & ~p1_stall_o`.
- `p1_stall_o`  out  1  pipeline stall; holds PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  1 = block write, 0 = block read.
- `mem_addr_o`  out  32  block address, `[4:0]` = 0.
- `mem_data_o`  out  256  writeback block.
- `mem_data_i`  in  256  refill block.
- `mem_ack_i`  in  1  one-cycle completion pulse from memory.

## Operation
- Address split: offset = `addr[4:0]`, word select = `addr[4:2]`, index = `addr[9:5]`, tag = `addr[31:10]` (22 b).
- Per line: valid, dirty, 22-bit tag, 256-bit data.
- Hit = valid & tag match.
  - Read hit: the selected word is driven combinationally.
  - Write hit: the word is merged into the line at the next edge and dirty is set.
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
  - IDLE: if `p1_req_i & ~hit`, go to MISS.
  - MISS: if the victim is valid and dirty, go to WRITEBACK; otherwise go to READMISS.
  - WRITEBACK: `mem_enable_o=1`, `mem_write_o=1`, `mem_addr_o={victim_tag,index,5'b0}`, `mem_data_o` = victim data. On `mem_ack_i`, go to READMISS.
  - READMISS: `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o={tag,index,5'b0}`. On `mem_ack_i`, write `mem_data_i` into the line (valid=1, dirty=0, new tag), then go to READMISSOK.
  - READMISSOK: one cycle with no memory request, then go to IDLE. The replayed access then hits; a store sets dirty at that point.
- `p1_stall_o = p1_req_i & (~hit | state != IDLE)`. The stall is combinational, so it rises in the same cycle as the miss.
- `p1_data_o = 32'b0` whenever there is no read hit in IDLE.
- Main memory sees only full-block transfers; nothing is ever written through on a store.

## Timing
- Reset, on the first edge with `rst_i=0`:
  - state = IDLE; all valid and dirty bits cleared. Tags and data are don't-care.
  - `mem_enable_o=0`, `mem_write_o=0`, `mem_addr_o=0`, `mem_data_o=0`, `p1_data_o=0`, `p1_stall_o=0`.
- Reset during WRITEBACK or READMISS abandons the transfer: `mem_enable_o` is low from the next cycle, and an ack that arrives later is ignored.
- Hit latency is 0 extra cycles.
- Clean miss latency: 1 (MISS) + N_rd (cycles up to and including the ack) + 1 (READMISSOK) cycles of stall, then the hit cycle.
- Dirty miss latency adds N_wr cycles.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are registered and stay stable from assertion through the ack cycle. They drop in the cycle after the ack, or switch directly to the refill request when leaving WRITEBACK.
- `mem_ack_i` is ignored outside WRITEBACK and READMISS.
- The CPU must hold `p1_*` inputs stable while `p1_stall_o=1`. `p1_req_i` dropping mid-miss does not abort the refill.
- A miss on index k never disturbs other lines. Victim and new line share the index, so the writeback address uses the stored tag.

## Structure
- Package `dcache_pkg` holds:
  - `TAG_W=22`, `IDX_W=5`, `OFS_W=5`, `BLOCK_BITS=256`.
  - FSM enum `dcache_state_t`.
  - Struct `dcache_tag_t` {valid, dirty, tag}.
- Sub-module `dcache_sram`: tag and data arrays, asynchronous read, synchronous write with enable. It also contains the word-merge for store hits.
- `dcache_ctrl` contains the FSM, hit compare, stall logic and memory interface registers.

## Test plan
- Reset, then load from 0x0000_0040 with memory returning a block whose word 0 is 0x1234_5678 after a 10-cycle ack:
  - `p1_stall_o` is high for 12 cycles.
  - Exactly one read request is issued, at `mem_addr_o=0x40`.
  - `p1_data_o=0x1234_5678` on the hit cycle.
- Store 0xDEAD_BEEF to 0x44 after the previous line is resident: no stall, no memory request; a following load of 0x44 returns 0xDEAD_BEEF.
- Load 0x0000_0440 (same index, new tag) with line 0x40 dirty:
  - A block write to 0x40 occurs with word 1 = 0xDEAD_BEEF.
  - It is followed by a read of 0x440.
  - Stall length = 1 + N_wr + N_rd + 1.
- Store miss to a clean invalid line at 0x80: refill, then the store merges; the line is dirty and the other 7 words match the memory data.
- Assert `rst_i=0` while in READMISS:
  - `mem_enable_o` is 0 on the next cycle and the state is IDLE.
  - A late `mem_ack_i` causes no array write.
  - The next access to the same address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, FSM encoding and line-metadata types for the L1 data cache.
// Address layout: tag = addr[31:10], index = addr[9:5], word = addr[4:2].
package dcache_pkg;

  localparam int TAG_W      = 22;
  localparam int IDX_W      = 5;
  localparam int OFS_W      = 5;
  localparam int BLOCK_BITS = 256;
  localparam int WORD_W     = 32;
  localparam int WSEL_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_READMISS,
    ST_READMISSOK
  } dcache_state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } dcache_tag_t;

  function automatic logic [BLOCK_BITS-1:0] merge_word(
    input logic [BLOCK_BITS-1:0] blk,
    input logic [WSEL_W-1:0]     sel,
    input logic [WORD_W-1:0]     word
  );
    logic [BLOCK_BITS-1:0] res;
    res = blk;
    res[sel*WORD_W +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side (MEM stage) and memory-side (block transfer) buses of the data cache.
// The cache is the slave of the CPU bus and the master of the memory bus.
interface dcache_cpu_if;
  logic        req;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (output req, read, write, addr, wdata, input rdata, stall);
  modport slave  (input req, read, write, addr, wdata, output rdata, stall);
endinterface

interface dcache_mem_if;
  import dcache_pkg::*;
  logic                  enable;
  logic                  write;
  logic [31:0]           addr;
  logic [BLOCK_BITS-1:0] wdata;
  logic [BLOCK_BITS-1:0] rdata;
  logic                  ack;

  modport master (output enable, write, addr, wdata, input rdata, ack);
  modport slave  (input enable, write, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dcache_sram.sv
// Tag/data arrays: asynchronous read, synchronous write. A refill replaces the
// whole line; a store hit merges one word and marks the line dirty.
module dcache_sram import dcache_pkg::*; #(
  parameter int NUM_LINES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      idx,
  output dcache_tag_t           line,
  output logic [BLOCK_BITS-1:0] line_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [BLOCK_BITS-1:0] fill_data,
  input  logic                  word_en,
  input  logic [WSEL_W-1:0]     word_sel,
  input  logic [WORD_W-1:0]     word_data
);

  logic [NUM_LINES-1:0]  valid;
  logic [NUM_LINES-1:0]  dirty;
  logic [TAG_W-1:0]      tags [NUM_LINES];
  logic [BLOCK_BITS-1:0] data [NUM_LINES];

  assign line      = '{valid: valid[idx], dirty: dirty[idx], tag: tags[idx]};
  assign line_data = data[idx];

  // Only the status bits are reset; tags and data are meaningless until valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_data;
    end else if (word_en) begin
      data[idx] <= merge_word(data[idx], word_sel, word_data);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit compare,
// combinational stall, miss FSM and registered block-transfer requests.
module dcache_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int BLOCK_BITS = 256
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);
  import dcache_pkg::*;

  dcache_state_t         state, state_nx;
  logic [31:OFS_W]       miss_blk;
  logic [31:OFS_W]       acc_blk;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WSEL_W-1:0]     wsel;
  dcache_tag_t           line;
  logic [BLOCK_BITS-1:0] line_data;
  logic                  hit, load, store, read_hit, fill_en, word_en;

  logic                  en_q, en_nx, wr_q, wr_nx;
  logic [31:0]           addr_q, addr_nx;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_nx;

  // Once a miss is taken the line address is frozen, so a CPU that drops req
  // mid-miss cannot redirect the refill.
  assign acc_blk  = (state == ST_IDLE) ? cpu.addr[31:OFS_W] : miss_blk;
  assign idx      = acc_blk[OFS_W +: IDX_W];
  assign tag      = acc_blk[OFS_W+IDX_W +: TAG_W];
  assign wsel     = cpu.addr[2 +: WSEL_W];

  assign hit      = line.valid && (line.tag == tag);
  assign store    = cpu.write;
  assign load     = cpu.read && !cpu.write;
  assign read_hit = (state == ST_IDLE) && cpu.req && load && hit;
  assign fill_en  = rst_i && (state == ST_READMISS) && mem.ack;
  assign word_en  = rst_i && (state == ST_IDLE) && cpu.req && store && hit;

  assign cpu.stall = cpu.req && (!hit || (state != ST_IDLE));
  assign cpu.rdata = read_hit ? line_data[wsel*WORD_W +: WORD_W] : '0;

  assign mem.enable = en_q;
  assign mem.write  = wr_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;

  dcache_sram #(.NUM_LINES(NUM_LINES)) u_sram (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .idx       (idx),
    .line      (line),
    .line_data (line_data),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_data (mem.rdata),
    .word_en   (word_en),
    .word_sel  (wsel),
    .word_data (cpu.wdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      en_q    <= en_nx;
      wr_q    <= wr_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE) miss_blk <= cpu.addr[31:OFS_W];
  end

  always_comb begin
    state_nx = state;
    en_nx    = en_q;
    wr_nx    = wr_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    case (state)
      ST_IDLE: if (cpu.req && !hit) state_nx = ST_MISS;
      ST_MISS: begin
        en_nx = 1'b1;
        if (line.valid && line.dirty) begin
          state_nx = ST_WRITEBACK;
          wr_nx    = 1'b1;
          addr_nx  = {line.tag, idx, {OFS_W{1'b0}}};
          wdata_nx = line_data;
        end else begin
          state_nx = ST_READMISS;
          wr_nx    = 1'b0;
          addr_nx  = {tag, idx, {OFS_W{1'b0}}};
        end
      end
      // Straight from the writeback ack into the refill request, no idle gap.
      ST_WRITEBACK: if (mem.ack) begin
        state_nx = ST_READMISS;
        wr_nx    = 1'b0;
        addr_nx  = {tag, idx, {OFS_W{1'b0}}};
      end
      ST_READMISS: if (mem.ack) begin
        state_nx = ST_READMISSOK;
        en_nx    = 1'b0;
        wr_nx    = 1'b0;
        addr_nx  = '0;
        wdata_nx = '0;
      end
      ST_READMISSOK: state_nx = ST_IDLE;
      default:       state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// accesses scored against a line-level cache model and a block memory model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dcache_cpu_if cpu();
  dcache_mem_if mem();

  dcache_ctrl #(.NUM_LINES(32), .BLOCK_BITS(256)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .cpu   (cpu),
    .mem   (mem)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory responder state: ack arrives in the lat-th cycle a request is seen.
  int lat_rd = 1;
  int lat_wr = 1;
  bit late_ack = 0;
  int unstable = 0;
  int cnt = 0;
  logic [31:0]  t_addr;
  bit           t_wr;
  logic [255:0] t_data;
  logic [255:0] mem_store [logic [31:0]];
  bit           q_wr [$];
  logic [31:0]  q_addr [$];
  logic [255:0] q_data [$];

  // Reference model of cache contents and of main memory.
  bit           mvalid [32];
  bit           mdirty [32];
  logic [21:0]  mtag   [32];
  logic [255:0] mdata  [32];
  logic [255:0] gmem [logic [31:0]];
  int           e_stall, e_ntx;
  bit           e_wb;
  logic [31:0]  e_wb_addr, e_rd_addr, e_rdata;
  logic [255:0] e_wb_data;

  // Observations from the last access.
  int           o_stall;
  logic [31:0]  o_rdata;
  logic         o_en;

  function automatic logic [255:0] init_blk(input logic [31:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(k) << 20) ^ 32'h5A5A_0000;
    return r;
  endfunction

  always @(negedge clk) begin
    mem.ack = 1'b0;
    if (late_ack) begin
      late_ack  = 0;
      mem.ack   = 1'b1;
      mem.rdata = {8{32'hBAD0_0BAD}};
    end else if (mem.enable) begin
      cnt++;
      if (cnt == 1) begin
        t_addr = mem.addr; t_wr = mem.write; t_data = mem.wdata;
      end else if (mem.addr !== t_addr || mem.write !== t_wr || (t_wr && mem.wdata !== t_data)) begin
        unstable++;
      end
      if (cnt >= (t_wr ? lat_wr : lat_rd)) begin
        mem.ack = 1'b1;
        cnt = 0;
        q_wr.push_back(t_wr); q_addr.push_back(t_addr); q_data.push_back(t_data);
        if (t_wr) mem_store[t_addr] = t_data;
        else mem.rdata = mem_store.exists(t_addr) ? mem_store[t_addr] : init_blk(t_addr);
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
  endtask

  // Predicts stall length, memory traffic and load data, then updates the model.
  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int i, w;
    logic [21:0] t;
    logic [31:0] blk;
    i = int'(a[9:5]); w = int'(a[4:2]); t = a[31:10]; blk = {a[31:5], 5'b0};
    e_wb = 0; e_ntx = 0; e_stall = 0;
    if (!(mvalid[i] && mtag[i] == t)) begin
      e_stall = 3 + lat_rd;
      e_ntx = 1;
      if (mvalid[i] && mdirty[i]) begin
        e_wb = 1; e_ntx = 2; e_stall += lat_wr;
        e_wb_addr = {mtag[i], a[9:5], 5'b0};
        e_wb_data = mdata[i];
        gmem[e_wb_addr] = mdata[i];
      end
      e_rd_addr = blk;
      mdata[i] = gmem.exists(blk) ? gmem[blk] : init_blk(blk);
      mvalid[i] = 1; mdirty[i] = 0; mtag[i] = t;
    end
    if (wr) begin
      mdata[i][w*32 +: 32] = d; mdirty[i] = 1; e_rdata = 32'h0;
    end else begin
      e_rdata = mdata[i][w*32 +: 32];
    end
  endtask

  // Called just after a rising edge; returns just after the hit cycle's edge.
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit both);
    q_wr.delete(); q_addr.delete(); q_data.delete();
    cpu.req = 1; cpu.write = wr; cpu.read = both | ~wr; cpu.addr = a; cpu.wdata = d;
    o_stall = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!cpu.stall) break;
      o_stall++;
    end
    o_rdata = cpu.rdata;
    o_en = mem.enable;
    @(posedge clk); #1;
    cpu.req = 0; cpu.read = 0; cpu.write = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (cpu.stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", cpu.stall); end
    tests_run++; if (cpu.rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", cpu.rdata); end
    tests_run++; if (mem.enable !== 1'b0) begin tests_failed++; $display("FAIL reset_enable: got %b want 0", mem.enable); end
    tests_run++; if (mem.write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b want 0", mem.write); end
    tests_run++; if (mem.addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", mem.addr); end
    tests_run++; if (mem.wdata !== 256'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0", mem.wdata); end
    @(posedge clk); #1;
    rst_n = 1;
    model_clear();
  endtask

  // Ack on the 9th request cycle = 10 cycles after the miss is seen: 12 stalls.
  task automatic test_first_load();
    lat_rd = 9;
    model_access(0, 32'h40, 0);
    do_access(0, 32'h40, 0, 0);
    tests_run++; if (o_stall !== 12) begin tests_failed++; $display("FAIL first_load_stall: got %0d want 12", o_stall); end
    tests_run++; if (q_wr.size() !== 1) begin tests_failed++; $display("FAIL first_load_nreq: got %0d want 1", q_wr.size()); end
    if (q_wr.size() == 1) begin
      tests_run++; if (q_wr[0] !== 1'b0 || q_addr[0] !== 32'h40) begin tests_failed++; $display("FAIL first_load_req: got wr=%b addr=%h want wr=0 addr=00000040", q_wr[0], q_addr[0]); end
    end
    tests_run++; if (o_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL first_load_data: got %h want 12345678", o_rdata); end
  endtask

  task automatic test_store_hit();
    model_access(1, 32'h44, 32'hDEAD_BEEF);
    do_access(1, 32'h44, 32'hDEAD_BEEF, 0);
    tests_run++; if (o_stall !== 0 || q_wr.size() !== 0) begin tests_failed++; $display("FAIL store_hit: got stall=%0d nreq=%0d want 0/0", o_stall, q_wr.size()); end
    model_access(0, 32'h44, 0);
    do_access(0, 32'h44, 0, 0);
    tests_run++; if (o_stall !== 0 || q_wr.size() !== 0) begin tests_failed++; $display("FAIL load_hit: got stall=%0d nreq=%0d want 0/0", o_stall, q_wr.size()); end
    tests_run++; if (o_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL load_after_store: got %h want deadbeef", o_rdata); end
    model_access(0, 32'h40, 0);
    do_access(0, 32'h40, 0, 0);
    tests_run++; if (o_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL neighbour_word: got %h want 12345678", o_rdata); end
  endtask

  task automatic test_dirty_evict();
    logic [255:0] wb;
    lat_wr = 4; lat_rd = 6;
    model_access(0, 32'h440, 0);
    do_access(0, 32'h440, 0, 0);
    tests_run++; if (o_stall !== 13) begin tests_failed++; $display("FAIL evict_stall: got %0d want 13", o_stall); end
    tests_run++; if (q_wr.size() !== 2) begin tests_failed++; $display("FAIL evict_nreq: got %0d want 2", q_wr.size()); end
    if (q_wr.size() == 2) begin
      wb = q_data[0];
      tests_run++; if (q_wr[0] !== 1'b1 || q_addr[0] !== 32'h40) begin tests_failed++; $display("FAIL evict_wb_req: got wr=%b addr=%h want wr=1 addr=00000040", q_wr[0], q_addr[0]); end
      tests_run++; if (wb[63:0] !== 64'hDEAD_BEEF_1234_5678) begin tests_failed++; $display("FAIL evict_wb_words: got %h want deadbeef12345678", wb[63:0]); end
      tests_run++; if (q_wr[1] !== 1'b0 || q_addr[1] !== 32'h440) begin tests_failed++; $display("FAIL evict_refill_req: got wr=%b addr=%h want wr=0 addr=00000440", q_wr[1], q_addr[1]); end
    end
    tests_run++; if (o_rdata !== e_rdata) begin tests_failed++; $display("FAIL evict_data: got %h want %h", o_rdata, e_rdata); end
  endtask

  task automatic test_store_miss();
    logic [255:0] exp_blk;
    logic [31:0]  exp_w1;
    lat_wr = 2; lat_rd = 2;
    exp_blk = init_blk(32'h80);
    exp_w1 = exp_blk[63:32];
    exp_blk[31:0] = 32'hCAFE_F00D;
    model_access(1, 32'h80, 32'hCAFE_F00D);
    do_access(1, 32'h80, 32'hCAFE_F00D, 0);
    tests_run++; if (o_stall !== 5 || q_wr.size() !== 1) begin tests_failed++; $display("FAIL store_miss: got stall=%0d nreq=%0d want 5/1", o_stall, q_wr.size()); end
    model_access(0, 32'h84, 0);
    do_access(0, 32'h84, 0, 0);
    tests_run++; if (o_stall !== 0 || o_rdata !== exp_w1) begin tests_failed++; $display("FAIL store_miss_neighbour: got stall=%0d data=%h want 0/%h", o_stall, o_rdata, exp_w1); end
    model_access(0, 32'h880, 0);
    do_access(0, 32'h880, 0, 0);
    tests_run++; if (o_stall !== 7 || q_wr.size() !== 2) begin tests_failed++; $display("FAIL store_miss_evict: got stall=%0d nreq=%0d want 7/2", o_stall, q_wr.size()); end
    if (q_wr.size() == 2) begin
      tests_run++; if (q_addr[0] !== 32'h80 || q_data[0] !== exp_blk) begin tests_failed++; $display("FAIL store_miss_wb: got addr=%h data=%h want addr=00000080 data=%h", q_addr[0], q_data[0], exp_blk); end
    end
  endtask

  task automatic test_random();
    bit wr, both;
    logic [31:0] a, d;
    for (int n = 0; n < 80; n++) begin
      lat_rd = $urandom_range(1, 4);
      lat_wr = $urandom_range(1, 4);
      wr   = 1'($urandom_range(0, 1));
      both = wr && ($urandom_range(0, 3) == 0);
      a = {22'($urandom_range(1, 3)), 5'($urandom_range(8, 11)), 3'($urandom_range(0, 7)), 2'b00};
      d = $urandom;
      model_access(wr, a, d);
      do_access(wr, a, d, both);
      tests_run++; if (o_stall !== e_stall) begin tests_failed++; $display("FAIL rand_stall[%0d]: addr=%h got %0d want %0d", n, a, o_stall, e_stall); end
      tests_run++; if (q_wr.size() !== e_ntx) begin tests_failed++; $display("FAIL rand_nreq[%0d]: got %0d want %0d", n, q_wr.size(), e_ntx); end
      if (q_wr.size() == e_ntx && e_ntx > 0) begin
        if (e_wb) begin
          tests_run++;
          if (q_wr[0] !== 1'b1 || q_addr[0] !== e_wb_addr || q_data[0] !== e_wb_data) begin
            tests_failed++; $display("FAIL rand_wb[%0d]: got addr=%h data=%h want addr=%h data=%h", n, q_addr[0], q_data[0], e_wb_addr, e_wb_data);
          end
        end
        tests_run++;
        if (q_wr[e_ntx-1] !== 1'b0 || q_addr[e_ntx-1] !== e_rd_addr) begin
          tests_failed++; $display("FAIL rand_refill[%0d]: got wr=%b addr=%h want wr=0 addr=%h", n, q_wr[e_ntx-1], q_addr[e_ntx-1], e_rd_addr);
        end
      end
      tests_run++; if (o_rdata !== e_rdata) begin tests_failed++; $display("FAIL rand_data[%0d]: addr=%h got %h want %h", n, a, o_rdata, e_rdata); end
      tests_run++; if (o_en !== 1'b0) begin tests_failed++; $display("FAIL rand_idle_enable[%0d]: got %b want 0", n, o_en); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    tests_run++; if (unstable !== 0) begin tests_failed++; $display("FAIL mem_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_reset_mid_refill();
    bit found;
    lat_rd = 1000; lat_wr = 1;
    cpu.req = 1; cpu.read = 1; cpu.write = 0; cpu.addr = 32'h0000_1000; cpu.wdata = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem.enable && !mem.write) begin found = 1; break; end
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rst_mid_reach: got no refill request want one"); end
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; cpu.req = 0; cpu.read = 0;
    @(negedge clk);
    tests_run++; if (mem.enable !== 1'b0 || mem.write !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_enable: got en=%b wr=%b want 0/0", mem.enable, mem.write); end
    model_clear();
    late_ack = 1;
    repeat (3) @(negedge clk);
    tests_run++; if (mem.enable !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_late_ack: got en=%b want 0", mem.enable); end
    @(posedge clk); #1;
    lat_rd = 3;
    model_access(0, 32'h0000_1000, 0);
    do_access(0, 32'h0000_1000, 0, 0);
    tests_run++; if (o_stall !== e_stall || q_wr.size() !== 1) begin tests_failed++; $display("FAIL rst_mid_remiss: got stall=%0d nreq=%0d want %0d/1", o_stall, q_wr.size(), e_stall); end
    tests_run++; if (o_rdata !== e_rdata) begin tests_failed++; $display("FAIL rst_mid_data: got %h want %h", o_rdata, e_rdata); end
  endtask

  initial begin
    logic [255:0] b;
    cpu.req = 0; cpu.read = 0; cpu.write = 0; cpu.addr = 0; cpu.wdata = 0;
    mem.ack = 0; mem.rdata = '0;
    b = init_blk(32'h40);
    b[31:0] = 32'h1234_5678;
    mem_store[32'h40] = b;
    gmem[32'h40] = b;
    test_reset();
    test_first_load();
    test_store_hit();
    test_dirty_evict();
    test_store_miss();
    test_random();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
